// File: rtl/systolic_pkg.sv
// Definitions shared by the systolic controller and its result drain:
// drain FSM encoding, index-width rule and flat-bus element slicing.
package systolic_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // Index counters never collapse to zero width, even for N=1.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Element k of a flat result bus occupies bits [(k+1)*w-1 : k*w].
    function automatic int elem_lsb(input int k, input int w);
        return k * w;
    endfunction

    function automatic int elem_msb(input int k, input int w);
        return (k + 1) * w - 1;
    endfunction

endpackage

// File: rtl/result_drain_if.sv
// Valid/ready element stream leaving the result drain, tagged with
// row/column position and a last-element marker.
interface result_drain_if
    import systolic_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 3
);
    localparam int IDXW = idx_width(N);

    logic [W-1:0]    data;
    logic            valid;
    logic            ready;
    logic            last;
    logic [IDXW-1:0] row;
    logic [IDXW-1:0] col;

    modport master (
        output data,
        output valid,
        output last,
        output row,
        output col,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        input  row,
        input  col,
        output ready
    );

endinterface

// File: rtl/result_drain.sv
// Snapshots the N*N result vector on a sync strobe and streams it out
// row-major, one element per handshake, so the array can start over.
module result_drain
    import systolic_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic [W*N*N-1:0] i_C,
    result_drain_if.master   m_out,
    output logic             o_busy,
    output logic             o_overrun,
    input  logic             i_clr_ovr
);

    localparam int NN   = N * N;
    localparam int IDXW = idx_width(N);
    localparam int KW   = idx_width(NN);

    drain_state_t    r_state;
    drain_state_t    w_state_next;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   w_k_next;
    logic [IDXW-1:0] r_row;
    logic [IDXW-1:0] w_row_next;
    logic [IDXW-1:0] r_col;
    logic [IDXW-1:0] w_col_next;
    logic            r_overrun;
    logic [W-1:0]    r_buf  [NN];
    logic [W-1:0]    w_elem [NN];

    logic w_valid;
    logic w_xfer;
    logic w_last_k;
    logic w_last_xfer;
    logic w_capture;
    logic w_ovr_set;

    for (genvar gi = 0; gi < NN; gi++) begin : g_slice
        assign w_elem[gi] = i_C[elem_lsb(gi, W) +: W];
    end

    assign w_valid     = (r_state == DRAIN);
    assign w_xfer      = w_valid && m_out.ready;
    assign w_last_k    = (r_k == KW'(NN - 1));
    assign w_last_xfer = w_xfer && w_last_k;
    // A strobe is taken when idle, or when it coincides with the final
    // transfer so back-to-back results drain without a bubble.
    assign w_capture   = i_en && i_sync && ((r_state == IDLE) || w_last_xfer);
    assign w_ovr_set   = i_sync && (r_state == DRAIN) && !w_last_xfer;

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_row_next   = r_row;
        w_col_next   = r_col;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_state_next = DRAIN;
                    w_k_next     = '0;
                    w_row_next   = '0;
                    w_col_next   = '0;
                end
            end
            DRAIN: begin
                if (w_last_xfer) begin
                    w_state_next = w_capture ? DRAIN : IDLE;
                    w_k_next     = '0;
                    w_row_next   = '0;
                    w_col_next   = '0;
                end else if (w_xfer) begin
                    w_k_next = r_k + 1'b1;
                    if (r_col == IDXW'(N - 1)) begin
                        w_col_next = '0;
                        w_row_next = r_row + 1'b1;
                    end else begin
                        w_col_next = r_col + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_k       <= w_k_next;
            r_row     <= w_row_next;
            r_col     <= w_col_next;
            r_overrun <= w_ovr_set | (r_overrun & ~i_clr_ovr);
        end
    end

    // Buffer needs no reset: it is only observable while DRAIN, which
    // always follows a capture.
    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            r_buf <= w_elem;
        end
    end

    assign m_out.valid = w_valid;
    assign m_out.data  = w_valid ? r_buf[r_k] : '0;
    assign m_out.last  = w_valid && w_last_k;
    assign m_out.row   = r_row;
    assign m_out.col   = r_col;
    assign o_busy      = w_valid;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: expected elements are queued when a
// capture is driven and checked in order as the DUT hands them over.
module tb_result_drain;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int NN = N * N;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            sync;
    logic [W*NN-1:0] c_bus;
    logic            busy;
    logic            overrun;
    logic            clr_ovr;

    result_drain_if #(.W(W), .N(N)) sif ();

    result_drain #(.W(W), .N(N)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_sync    (sync),
        .i_C       (c_bus),
        .m_out     (sif),
        .o_busy    (busy),
        .o_overrun (overrun),
        .i_clr_ovr (clr_ovr)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   xfers = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_c(input logic [31:0] base);
        for (int k = 0; k < NN; k++) c_bus[k*W +: W] = base + 32'(k);
    endtask

    task automatic push_exp(input logic [31:0] base);
        exp_t e;
        for (int k = 0; k < NN; k++) begin
            e.data = base + 32'(k);
            e.row  = 2'(k / N);
            e.col  = 2'(k % N);
            e.last = (k == NN - 1);
            sb.push_back(e);
        end
    endtask

    // Compare the presented element (if any) against the scoreboard head,
    // retire it if this cycle is a transfer, then advance one clock.
    task automatic tick();
        exp_t e;
        if (sif.valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = sb[0];
                chk("data", sif.data, e.data);
                chk("row",  sif.row,  e.row);
                chk("col",  sif.col,  e.col);
                chk("last", sif.last, e.last);
                if (sif.ready === 1'b1) begin
                    void'(sb.pop_front());
                    xfers++;
                    $display("xfer data=%0h row=%0d col=%0d last=%0b", e.data, e.row, e.col, e.last);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_bounded(input string tag, input int budget);
        for (int c = 0; c < budget && sb.size() > 0; c++) tick();
        chk(tag, sb.size(), 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, sif.valid, 0);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_data"},  sif.data,  0);
        chk({tag, "_last"},  sif.last,  0);
        chk({tag, "_row"},   sif.row,   0);
        chk({tag, "_col"},   sif.col,   0);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        sync      = 1'b0;
        clr_ovr   = 1'b0;
        sif.ready = 1'b0;
        c_bus     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_overrun", overrun, 0);
        rst_n = 1'b1;

        // Basic drain with ready held high.
        load_c(32'h100);
        en = 1'b1; sync = 1'b1; sif.ready = 1'b1;
        push_exp(32'h100);
        tick();
        sync = 1'b0;
        chk("basic_latency_valid", sif.valid, 1);
        chk("basic_busy", busy, 1);
        for (int i = 0; i < NN; i++) tick();
        chk("basic_sb_empty", sb.size(), 0);
        chk("basic_valid_drop", sif.valid, 0);

        // Backpressure 1,0,0,1 repeating.
        xfers = 0;
        sync = 1'b1;
        push_exp(32'h100);
        tick();
        sync = 1'b0;
        for (int c = 0; c < 60 && sb.size() > 0; c++) begin
            sif.ready = ((c % 4) == 0) || ((c % 4) == 3);
            tick();
        end
        chk("bp_sb_empty", sb.size(), 0);
        chk("bp_xfer_count", xfers, NN);
        sif.ready = 1'b1;
        tick();
        chk("bp_valid_drop", sif.valid, 0);

        // Overrun: strobe while element 4 is presented.
        sync = 1'b1;
        push_exp(32'h100);
        tick();
        sync = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        load_c(32'h500);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("ovr_set", overrun, 1);
        drain_bounded("ovr_orig_data", 10);
        chk("ovr_valid_drop", sif.valid, 0);
        chk("ovr_sticky", overrun, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // Back-to-back recapture on the last transfer.
        load_c(32'h100);
        sync = 1'b1;
        push_exp(32'h100);
        tick();
        sync = 1'b0;
        for (int i = 0; i < NN - 1; i++) tick();
        chk("b2b_at_last", sif.last, 1);
        load_c(32'h200);
        sync = 1'b1;
        push_exp(32'h200);
        tick();
        sync = 1'b0;
        chk("b2b_no_bubble", sif.valid, 1);
        chk("b2b_first_data", sif.data, 32'h200);
        chk("b2b_no_overrun", overrun, 0);
        drain_bounded("b2b_sb_empty", 12);
        chk("b2b_valid_drop", sif.valid, 0);

        // Reset mid-drain after element 3 has transferred.
        load_c(32'h100);
        sync = 1'b1;
        push_exp(32'h100);
        tick();
        sync = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        sif.ready = 1'b0;
        rst_n = 1'b0;
        tick();
        sb.delete();
        chk_idle_outputs("midrst");
        rst_n = 1'b1;
        sif.ready = 1'b1;
        load_c(32'h300);
        sync = 1'b1;
        push_exp(32'h300);
        tick();
        sync = 1'b0;
        chk("midrst_restart_data", sif.data, 32'h300);
        drain_bounded("midrst_sb_empty", 12);

        // Enable gating.
        en = 1'b0;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        chk("en_gate_valid", sif.valid, 0);
        chk("en_gate_busy", busy, 0);
        en = 1'b1;
        load_c(32'h400);
        sync = 1'b1;
        push_exp(32'h400);
        tick();
        sync = 1'b0;
        en = 1'b0;
        drain_bounded("en_low_drain", 12);
        chk("en_low_valid_drop", sif.valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
